// File: rtl/max30102_pkg.sv
// rtl/max30102_pkg.sv - shared types and constants for the MAX30102 init sequencer
package max30102_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PU_WAIT,
    ST_FETCH,
    ST_LATCH,
    ST_WRITE,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERROR
  } init_state_t;

  localparam logic [23:0] PU_WAIT_DEFAULT = 24'd50_000;

  // Table word layout: {reg, data}
  localparam int REG_MSB  = 15;
  localparam int REG_LSB  = 8;
  localparam int DATA_MSB = 7;

endpackage

// File: rtl/max30102_init_ctrl_if.sv
// rtl/max30102_init_ctrl_if.sv - I2C byte-write request/done handshake between sequencer and I2C master
interface max30102_init_ctrl_if;

  logic       i2c_req;
  logic [7:0] i2c_dev;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_wdata;
  logic       i2c_done;
  logic       i2c_nack;

  modport master (
    output i2c_req, i2c_dev, i2c_reg, i2c_wdata,
    input  i2c_done, i2c_nack
  );

  modport slave (
    input  i2c_req, i2c_dev, i2c_reg, i2c_wdata,
    output i2c_done, i2c_nack
  );

endinterface

// File: rtl/max30102_wait_timer.sv
// rtl/max30102_wait_timer.sv - loadable down-counter; expired while the count sits at zero
module max30102_wait_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = cnt_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/max30102_init_ctrl.sv
// rtl/max30102_init_ctrl.sv - walks the MAX30102 init table as I2C register writes
// Optional NACK retry is compiled in with `define MAX30102_INIT_RETRY_EN.
module max30102_init_ctrl
  import max30102_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 16,
  parameter logic [23:0] PU_WAIT    = PU_WAIT_DEFAULT,
  parameter int          RETRY_MAX  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            lut_size,
  input  logic [7:0]            dev_id,
  output logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [DATA_WIDTH-1:0] tbl_q,
  max30102_init_ctrl_if.master  i2c,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_err,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  if (RETRY_MAX < 1) begin : g_bad_retry_max
    $error("RETRY_MAX must be at least 1");
  end

  init_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  req_q, req_d;
  logic [7:0]            dev_q, dev_d;
  logic [7:0]            reg_q, reg_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic [ADDR_WIDTH-1:0] lut_n;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic                  timer_load;
  logic                  timer_expired;
  logic                  restart;
  logic                  can_retry;

  assign lut_n    = ADDR_WIDTH'(lut_size);
  assign last_idx = lut_n - ADDR_WIDTH'(1);
  assign restart  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);

`ifdef MAX30102_INIT_RETRY_EN
  localparam int RETRY_W = $clog2(RETRY_MAX + 1);

  logic [RETRY_W-1:0] retry_q, retry_d;

  assign can_retry = (retry_q < RETRY_W'(RETRY_MAX));

  always_comb begin
    retry_d = retry_q;
    if (restart || state_q == ST_FETCH) begin
      retry_d = '0;
    end else if (state_q == ST_WAIT_ACK && i2c.i2c_done && i2c.i2c_nack && can_retry) begin
      retry_d = retry_q + RETRY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`else
  assign can_retry = 1'b0;
`endif

  max30102_wait_timer #(.WIDTH(24)) u_pu_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .cnt_val (PU_WAIT),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_PU_WAIT;
      ST_PU_WAIT:  if (timer_expired) state_d = (lut_n == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH:    state_d = ST_LATCH;
      ST_LATCH:    state_d = ST_WRITE;
      ST_WRITE:    state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (i2c.i2c_done) begin
          if (!i2c.i2c_nack) begin
            state_d = (idx_q == last_idx) ? ST_DONE : ST_FETCH;
          end else begin
            state_d = can_retry ? ST_WRITE : ST_ERROR;
          end
        end
      end
      ST_DONE, ST_ERROR: if (start) state_d = ST_PU_WAIT;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    req_d      = req_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    timer_load = restart;

    if (restart) begin
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_addr_d = '0;
    end

    case (state_q)
      ST_PU_WAIT: if (timer_expired) idx_d = '0;
      ST_LATCH: begin
        dev_d   = dev_id;
        reg_d   = tbl_q[REG_MSB:REG_LSB];
        wdata_d = tbl_q[DATA_MSB:0];
      end
      ST_WRITE:   req_d = 1'b1;
      ST_WAIT_ACK: begin
        if (i2c.i2c_done) begin
          req_d = 1'b0;
          if (state_d == ST_FETCH) idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      default: ;
    endcase

    // Sticky flags are set on entry so they rise one cycle after the deciding event.
    if (state_d == ST_DONE && state_q != ST_DONE) done_d = 1'b1;
    if (state_d == ST_ERROR && state_q != ST_ERROR) begin
      err_d      = 1'b1;
      err_addr_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      req_q      <= 1'b0;
      dev_q      <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      idx_q      <= idx_d;
      req_q      <= req_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign tbl_addr      = idx_q;
  assign i2c.i2c_req   = req_q;
  assign i2c.i2c_dev   = dev_q;
  assign i2c.i2c_reg   = reg_q;
  assign i2c.i2c_wdata = wdata_q;
  assign busy          = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  assign init_done     = done_q;
  assign init_err      = err_q;
  assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_max30102_init_ctrl.sv
// tb/tb_max30102_init_ctrl.sv - directed scoreboard bench for max30102_init_ctrl
module tb_max30102_init_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  lut_size;
  logic [7:0]  dev_id;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_q;
  logic        busy, init_done, init_err;
  logic [7:0]  err_addr;

  max30102_init_ctrl_if bus ();

  max30102_init_ctrl #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (16),
    .PU_WAIT    (24'd20),
    .RETRY_MAX  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lut_size  (lut_size),
    .dev_id    (dev_id),
    .tbl_addr  (tbl_addr),
    .tbl_q     (tbl_q),
    .i2c       (bus),
    .busy      (busy),
    .init_done (init_done),
    .init_err  (init_err),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [0:15];
  always @(posedge clk) tbl_q <= tbl[tbl_addr[3:0]];

  int          checks = 0;
  int          errors = 0;
  int          req_count = 0;
  logic [23:0] exp_q [$];
  bit          nack_plan [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_entry(input int i);
    exp_q.push_back({dev_id, tbl[i]});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_status(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (init_done || init_err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_reqs(input int n, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (req_count >= n && bus.i2c_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // I2C slave model: answers each request after a few cycles and scores it.
  initial begin : slave
    bit          in_txn;
    bit          nack;
    bit          gap_pending;
    bit          done_chk;
    int          wait_cnt;
    int          cyc;
    int          last_done_cyc;
    logic [23:0] cap;
    in_txn = 0; gap_pending = 0; done_chk = 0; wait_cnt = 0; cyc = 0; last_done_cyc = 0;
    cap = '0;
    bus.i2c_done = 1'b0;
    bus.i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;
      if (done_chk) begin
        check("init_done_after_final_ack", init_done, 1);
        done_chk = 0;
      end
      if (!rst_n) begin
        in_txn = 0;
        gap_pending = 0;
      end else if (in_txn) begin
        if (!bus.i2c_req) begin
          check("req_held_until_done", bus.i2c_req, 1);
          in_txn = 0;
        end else begin
          wait_cnt++;
          if (wait_cnt == 3) begin
            nack = (nack_plan.size() != 0) ? nack_plan.pop_front() : 1'b0;
            bus.i2c_done = 1'b1;
            bus.i2c_nack = nack;
            check("fields_stable", {bus.i2c_dev, bus.i2c_reg, bus.i2c_wdata}, cap);
            done_chk      = !nack && (exp_q.size() == 0);
            gap_pending   = !nack && (exp_q.size() != 0);
            last_done_cyc = cyc;
            in_txn        = 0;
          end
        end
      end else if (bus.i2c_req) begin
        in_txn   = 1;
        wait_cnt = 0;
        req_count++;
        cap = {bus.i2c_dev, bus.i2c_reg, bus.i2c_wdata};
        if (gap_pending) check("ack_to_req_cycles", cyc - last_done_cyc, 4);
        gap_pending = 0;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_req: observed %06h expected no request", cap);
        end
        if (exp_q.size() != 0) check("req_fields", cap, exp_q.pop_front());
      end
    end
  end

  initial begin : main
    bit ok;
    int rc;
    tbl[0] = 16'h02C0; tbl[1] = 16'h0300; tbl[2] = 16'h0400; tbl[3] = 16'h0500;
    tbl[4] = 16'h0600; tbl[5] = 16'h084F; tbl[6] = 16'h0903; tbl[7] = 16'h0A27;
    tbl[8] = 16'h0C24; tbl[9] = 16'h0D32;
    for (int i = 10; i < 16; i++) tbl[i] = 16'hFFFF;
    rst_n = 1'b0; start = 1'b0; lut_size = 8'd10; dev_id = 8'hAE;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_i2c_req", bus.i2c_req, 0);
    check("rst_i2c_fields", {bus.i2c_dev, bus.i2c_reg, bus.i2c_wdata}, 0);
    check("rst_busy", busy, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_err", init_err, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_tbl_addr", tbl_addr, 0);

    // Full table, all ACK, with an ignored start mid-sequence
    rc = req_count;
    for (int i = 0; i < 10; i++) push_entry(i);
    pulse_start();
    check("busy_after_start", busy, 1);
    wait_reqs(rc + 3, 1000, ok);
    check("wait_third_req", ok, 1);
    pulse_start();
    wait_status(3000, ok);
    check("t1_finished", ok, 1);
    check("t1_init_done", init_done, 1);
    check("t1_init_err", init_err, 0);
    check("t1_busy", busy, 0);
    check("t1_req_count", req_count - rc, 10);
    check("t1_scoreboard_empty", exp_q.size(), 0);

`ifdef MAX30102_INIT_RETRY_EN
    // Entry 6 NACKed twice then ACKed
    rc = req_count;
    for (int i = 0; i < 10; i++) begin
      push_entry(i);
      if (i == 6) begin push_entry(6); push_entry(6); end
    end
    for (int i = 0; i < 6; i++) nack_plan.push_back(1'b0);
    nack_plan.push_back(1'b1); nack_plan.push_back(1'b1);
    pulse_start();
    wait_status(3000, ok);
    check("retry_finished", ok, 1);
    check("retry_init_done", init_done, 1);
    check("retry_init_err", init_err, 0);
    check("retry_req_count", req_count - rc, 12);
    check("retry_scoreboard_empty", exp_q.size(), 0);
    nack_plan.delete();
`endif

    // Unrecoverable NACK on entry 3
    for (int i = 0; i < 4; i++) push_entry(i);
    for (int i = 0; i < 3; i++) nack_plan.push_back(1'b0);
    nack_plan.push_back(1'b1);
`ifdef MAX30102_INIT_RETRY_EN
    for (int i = 0; i < 3; i++) begin push_entry(3); nack_plan.push_back(1'b1); end
`endif
    pulse_start();
    wait_status(3000, ok);
    check("err_finished", ok, 1);
    check("err_init_err", init_err, 1);
    check("err_err_addr", err_addr, 3);
    check("err_i2c_req", bus.i2c_req, 0);
    check("err_init_done", init_done, 0);
    check("err_busy", busy, 0);
    check("err_scoreboard_empty", exp_q.size(), 0);
    nack_plan.delete();

    // Empty table restarted from ERROR
    lut_size = 8'd0;
    rc = req_count;
    pulse_start();
    check("restart_clears_err", init_err, 0);
    check("restart_clears_err_addr", err_addr, 0);
    wait_status(500, ok);
    check("lut0_finished", ok, 1);
    check("lut0_init_done", init_done, 1);
    check("lut0_no_req", req_count - rc, 0);

    // Re-run after DONE with entry 6 changed and a new device address
    lut_size = 8'd10;
    tbl[6] = 16'h0902;
    dev_id = 8'hAC;
    rc = req_count;
    for (int i = 0; i < 10; i++) push_entry(i);
    pulse_start();
    check("rerun_clears_done", init_done, 0);
    wait_status(3000, ok);
    check("rerun_init_done", init_done, 1);
    check("rerun_req_count", req_count - rc, 10);
    check("rerun_scoreboard_empty", exp_q.size(), 0);

    // Reset while a request is outstanding
    rc = req_count;
    for (int i = 0; i < 10; i++) push_entry(i);
    pulse_start();
    wait_reqs(rc + 2, 1000, ok);
    check("wait_req_before_reset", ok, 1);
    rst_n = 1'b0;
    #1;
    check("reset_i2c_req", bus.i2c_req, 0);
    check("reset_flags", {busy, init_done, init_err}, 0);
    check("reset_fields", {bus.i2c_dev, bus.i2c_reg, bus.i2c_wdata}, 0);
    exp_q.delete();
    nack_plan.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rc = req_count;
    repeat (30) @(negedge clk);
    check("post_reset_idle_busy", busy, 0);
    check("post_reset_tbl_addr", tbl_addr, 0);
    check("post_reset_no_req", req_count - rc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
